rv32v_mem_lane_sequencer: RTL and testbench
===========================================

RV32V_MEM_LANE_SEQUENCER -- requirements
Module: rv32v_mem_lane_sequencer

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 load_ena  input  1  vector load issued from execute.
REQ-004 store_ena  input  1  vector store issued from execute; never high together with load_ena.
REQ-005 wen  input  2  per-lane element enable; bit0 = lane0, bit1 = lane1.
REQ-006 aluresult0 / aluresult1  input  32 each  byte address, lane0 / lane1.
REQ-007 storedata0 / storedata1  input  32 each  store element, LSB-aligned, lane0 / lane1.
REQ-008 eew_loadstore  input  2  access width: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-009 vd  input  5  destination vector register.
REQ-010 woffset0 / woffset1  input  5 each  element offset within vd, lane0 / lane1.
REQ-011 stall  output  1  hold execute->memory inputs stable.
REQ-012 dmem_ren / dmem_wen  output  1 each  data memory read / write request.
REQ-013 dmem_addr  output  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-014 dmem_byte_en  output  4  byte lanes for the access.
REQ-015 dmem_store  output  32  write data.
REQ-016 dmem_load  input  32  read data; valid in any cycle with dmem_ren=1 and dmem_busy=0.
REQ-017 dmem_busy  input  1  memory not done; a request completes in a cycle with busy=0.
REQ-018 wb_valid  output  1  one-cycle writeback strobe.
REQ-019 wb_wen  output  2  per-lane write enable to the vector register file.
REQ-020 wb_data0 / wb_data1  output  32 each  loaded elements, zero-extended.
REQ-021 wb_vd, wb_woffset0, wb_woffset1  output  5 each  registered copies of vd, woffset0 and woffset1.
REQ-022 wb_misaligned  output  1  at least one enabled lane was misaligned.

Function
REQ-023 The FSM SHALL use the states IDLE, LANE0, LANE1 and DONE.
REQ-024 Request acceptance: req = (load_ena|store_ena) & (wen!=0), evaluated in IDLE only; wen=00 SHALL be ignored, with no stall and no wb_valid.
REQ-025 On acceptance the block SHALL register all inputs except stall-related ones and go to LANE0 if wen[0]=1, else to LANE1.
REQ-026 stall SHALL equal (IDLE & req) | LANE0 | LANE1, and SHALL be low in DONE.
REQ-027 In LANE0 and LANE1, the lane address, width and data SHALL be taken from registered values only.
REQ-028 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0; such a lane SHALL issue no dmem request, spend one cycle in its state, clear its wb_wen bit and set wb_misaligned.
REQ-029 For an aligned lane, the block SHALL hold dmem_ren (load) or dmem_wen (store) high until the first cycle with dmem_busy=0.
REQ-030 On completion of a load, the block SHALL capture the lane result into the wb_data register.
REQ-031 Transition from LANE0: to LANE1 if reg wen[1]=1, else to DONE.
REQ-032 Transition from LANE1: to DONE.
REQ-033 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
REQ-034 Store data: byte replicated x4; half replicated x2; word as is.
REQ-035 Load extraction: byte = dmem_load[8*addr[1:0]+:8]; half = dmem_load[16*addr[1]+:16]; zero-extended to 32.
REQ-036 DONE SHALL assert wb_valid=1 for exactly one cycle, with wb_wen = reg wen & ~misaligned_lanes.
REQ-037 For stores, DONE SHALL force wb_wen=00.
REQ-038 DONE SHALL always return to IDLE; no request is accepted in DONE.
REQ-039 dmem_ren and dmem_wen SHALL never both be high, and SHALL be low in IDLE and DONE.
REQ-040 Latency (busy=0, both lanes aligned): accept at cycle N; lane0 at N+1; lane1 at N+2; wb_valid at N+3.

Reset
REQ-041 RST=1 at an edge SHALL force IDLE, abandoning any in-flight lane; the block SHALL re-issue nothing for it.
REQ-042 After reset, all outputs and registers SHALL be 0: stall, dmem_*, wb_valid, wb_wen, wb_data*, wb_vd, wb_woffset*, wb_misaligned.

Verification
REQ-043 Word load, wen=11, addr0=0x100, addr1=0x104, busy=0, mem returns 0xDEADBEEF then 0x12345678 -> dmem_addr 0x100 then 0x104; wb_valid at N+3, wb_wen=11, wb_data0=0xDEADBEEF, wb_data1=0x12345678.
REQ-044 Byte store, wen=01, addr0=0x203, data0=0xA5 -> dmem_wen one cycle, addr 0x200, byte_en 1000, store 0xA5A5A5A5; LANE1 skipped; wb_valid at N+2, wb_wen=00.
REQ-045 Half load, wen=11, addr0=0x302, busy high 3 cycles on lane0 -> dmem_ren held 4 cycles, stall high throughout; wb_data0 = dmem_load[31:16] zero-extended.
REQ-046 Misaligned word load, addr1=0x101, wen=11 -> lane1 issues no request; wb_wen=01, wb_misaligned=1.
REQ-047 RST asserted during LANE1 with busy=1 -> next cycle IDLE; dmem_ren=0, stall=0, wb_valid never pulses.
REQ-048 wen=00 with load_ena=1 -> stall=0, no dmem activity, no wb_valid.

Source files
------------

// File: rtl/rv32v_mem_lane_sequencer.sv
// Two-lane vector load/store sequencer: issues one data-memory access per enabled
// lane in turn, then presents a single writeback strobe to the vector register file.
module rv32v_mem_lane_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_ena,
  input  logic        store_ena,
  input  logic [1:0]  wen,
  input  logic [31:0] aluresult0,
  input  logic [31:0] aluresult1,
  input  logic [31:0] storedata0,
  input  logic [31:0] storedata1,
  input  logic [1:0]  eew_loadstore,
  input  logic [4:0]  vd,
  input  logic [4:0]  woffset0,
  input  logic [4:0]  woffset1,
  output logic        stall,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_byte_en,
  output logic [31:0] dmem_store,
  input  logic [31:0] dmem_load,
  input  logic        dmem_busy,
  output logic        wb_valid,
  output logic [1:0]  wb_wen,
  output logic [31:0] wb_data0,
  output logic [31:0] wb_data1,
  output logic [4:0]  wb_vd,
  output logic [4:0]  wb_woffset0,
  output logic [4:0]  wb_woffset1,
  output logic        wb_misaligned
);

  typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

  state_t      state;
  logic        is_load;
  logic [1:0]  lane_wen;
  logic [1:0]  eew;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] sdata0;
  logic [31:0] sdata1;
  logic [1:0]  mis_lanes;

  logic        req;
  logic        in_lane;
  logic [31:0] lane_addr;
  logic [31:0] lane_sdata;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        lane_mis;
  logic        lane_go;
  logic        lane_done;
  logic [31:0] load_elem;
  logic [1:0]  done_mis;
  logic [1:0]  wb_wen_next;

  assign req     = (load_ena | store_ena) & (wen != 2'b00);
  assign in_lane = (state == LANE0) || (state == LANE1);

  // The active lane's operands come only from the captured request.
  assign lane_addr  = (state == LANE1) ? addr1 : addr0;
  assign lane_sdata = (state == LANE1) ? sdata1 : sdata0;

  assign is_byte = (eew == 2'd0);
  assign is_half = (eew == 2'd1);
  assign is_word = eew[1];

  assign lane_mis  = (is_half & lane_addr[0]) | (is_word & (lane_addr[1:0] != 2'b00));
  assign lane_go   = in_lane & ~lane_mis;
  assign lane_done = in_lane & (lane_mis | ~dmem_busy);

  assign stall    = ((state == IDLE) & req) | in_lane;
  assign dmem_ren = lane_go & is_load;
  assign dmem_wen = lane_go & ~is_load;

  assign dmem_addr = lane_go ? {lane_addr[31:2], 2'b00} : 32'h0;

  always_comb begin
    dmem_byte_en = 4'b0000;
    dmem_store   = 32'h0;
    load_elem    = 32'h0;
    if (lane_go) begin
      if (is_byte) begin
        dmem_byte_en = 4'b0001 << lane_addr[1:0];
        load_elem    = {24'h0, dmem_load[{lane_addr[1:0], 3'b000} +: 8]};
      end else if (is_half) begin
        dmem_byte_en = 4'b0011 << {lane_addr[1], 1'b0};
        load_elem    = {16'h0, dmem_load[{lane_addr[1], 4'b0000} +: 16]};
      end else begin
        dmem_byte_en = 4'b1111;
        load_elem    = dmem_load;
      end
    end
    if (dmem_wen) begin
      if (is_byte) begin
        dmem_store = {4{lane_sdata[7:0]}};
      end else if (is_half) begin
        dmem_store = {2{lane_sdata[15:0]}};
      end else begin
        dmem_store = lane_sdata;
      end
    end
  end

  // Misalignment of the lane finishing this cycle must be folded into the final enables.
  assign done_mis    = mis_lanes | ((state == LANE1) ? {lane_mis, 1'b0} : {1'b0, lane_mis});
  assign wb_wen_next = is_load ? (lane_wen & ~done_mis) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      is_load       <= 1'b0;
      lane_wen      <= 2'b00;
      eew           <= 2'd0;
      addr0         <= 32'h0;
      addr1         <= 32'h0;
      sdata0        <= 32'h0;
      sdata1        <= 32'h0;
      mis_lanes     <= 2'b00;
      wb_valid      <= 1'b0;
      wb_wen        <= 2'b00;
      wb_data0      <= 32'h0;
      wb_data1      <= 32'h0;
      wb_vd         <= 5'd0;
      wb_woffset0   <= 5'd0;
      wb_woffset1   <= 5'd0;
      wb_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_load       <= load_ena;
            lane_wen      <= wen;
            eew           <= eew_loadstore;
            addr0         <= aluresult0;
            addr1         <= aluresult1;
            sdata0        <= storedata0;
            sdata1        <= storedata1;
            wb_vd         <= vd;
            wb_woffset0   <= woffset0;
            wb_woffset1   <= woffset1;
            mis_lanes     <= 2'b00;
            wb_misaligned <= 1'b0;
            wb_data0      <= 32'h0;
            wb_data1      <= 32'h0;
            state         <= wen[0] ? LANE0 : LANE1;
          end
        end
        LANE0: begin
          if (lane_done) begin
            if (lane_mis) begin
              mis_lanes[0]  <= 1'b1;
              wb_misaligned <= 1'b1;
            end else if (is_load) begin
              wb_data0 <= load_elem;
            end
            if (lane_wen[1]) begin
              state <= LANE1;
            end else begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_wen   <= wb_wen_next;
            end
          end
        end
        LANE1: begin
          if (lane_done) begin
            if (lane_mis) begin
              mis_lanes[1]  <= 1'b1;
              wb_misaligned <= 1'b1;
            end else if (is_load) begin
              wb_data1 <= load_elem;
            end
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_wen   <= wb_wen_next;
          end
        end
        DONE: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_mem_lane_sequencer.sv
// Directed bench for rv32v_mem_lane_sequencer: a vector table of single
// transactions plus hand-written busy, reset-abort and empty-request sequences.
module tb_rv32v_mem_lane_sequencer;

  logic        clk;
  logic        rst;
  logic        load_ena;
  logic        store_ena;
  logic [1:0]  wen;
  logic [31:0] aluresult0;
  logic [31:0] aluresult1;
  logic [31:0] storedata0;
  logic [31:0] storedata1;
  logic [1:0]  eew_loadstore;
  logic [4:0]  vd;
  logic [4:0]  woffset0;
  logic [4:0]  woffset1;
  logic        stall;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_store;
  logic [31:0] dmem_load;
  logic        dmem_busy;
  logic        wb_valid;
  logic [1:0]  wb_wen;
  logic [31:0] wb_data0;
  logic [31:0] wb_data1;
  logic [4:0]  wb_vd;
  logic [4:0]  wb_woffset0;
  logic [4:0]  wb_woffset1;
  logic        wb_misaligned;

  rv32v_mem_lane_sequencer dut (
    .clk(clk), .rst(rst), .load_ena(load_ena), .store_ena(store_ena), .wen(wen),
    .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1),
    .eew_loadstore(eew_loadstore), .vd(vd), .woffset0(woffset0), .woffset1(woffset1),
    .stall(stall), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_byte_en(dmem_byte_en), .dmem_store(dmem_store), .dmem_load(dmem_load),
    .dmem_busy(dmem_busy), .wb_valid(wb_valid), .wb_wen(wb_wen),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_vd(wb_vd),
    .wb_woffset0(wb_woffset0), .wb_woffset1(wb_woffset1), .wb_misaligned(wb_misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  typedef struct {
    logic        ld;
    logic [1:0]  wen;
    logic [1:0]  eew;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] sd0;
    logic [31:0] sd1;
    logic [4:0]  vd;
    logic [4:0]  wo0;
    logic [4:0]  wo1;
    int          busy_n;
    int          exp_lat;
    logic [1:0]  exp_wbwen;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic        exp_mis;
    int          exp_nreq;
    logic [31:0] exp_addr_first;
    logic [31:0] exp_addr_last;
    logic [3:0]  exp_be_first;
    logic [3:0]  exp_be_last;
    logic [31:0] exp_st_first;
    logic [31:0] exp_st_last;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];
  vec_t busy_vec;

  int total;
  int bad;

  int          res_lat;
  int          res_nreq;
  int          res_req_cycles;
  int          res_stall_low;
  int          res_both_hi;
  logic        res_stall_accept;
  logic        res_post_valid;
  logic        res_done_dmem;
  logic        res_done_stall;
  logic [1:0]  res_wbwen;
  logic [31:0] res_d0;
  logic [31:0] res_d1;
  logic        res_mis;
  logic [4:0]  res_vd;
  logic [4:0]  res_wo0;
  logic [4:0]  res_wo1;
  logic [31:0] res_addr_first;
  logic [31:0] res_addr_last;
  logic [3:0]  res_be_first;
  logic [3:0]  res_be_last;
  logic [31:0] res_st_first;
  logic [31:0] res_st_last;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_model = 32'hDEAD_BEEF;
      32'h0000_0104: mem_model = 32'h1234_5678;
      32'h0000_0300: mem_model = 32'hCAFE_F00D;
      default:       mem_model = 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    load_ena      = 1'b0;
    store_ena     = 1'b0;
    wen           = 2'b00;
    aluresult0    = 32'h0;
    aluresult1    = 32'h0;
    storedata0    = 32'h0;
    storedata1    = 32'h0;
    eew_loadstore = 2'd0;
    vd            = 5'd0;
    woffset0      = 5'd0;
    woffset1      = 5'd0;
    dmem_load     = 32'h0;
    dmem_busy     = 1'b0;
  endtask

  // Drives one request and plays the memory until the writeback strobe.
  task automatic applyStimulus(input vec_t v);
    res_lat = -1; res_nreq = 0; res_req_cycles = 0; res_stall_low = 0; res_both_hi = 0;
    res_done_dmem = 1'b0; res_done_stall = 1'b0; res_post_valid = 1'b0;
    res_addr_first = 32'hFFFF_FFFF; res_addr_last = 32'hFFFF_FFFF;
    res_be_first = 4'h0; res_be_last = 4'h0; res_st_first = 32'h0; res_st_last = 32'h0;
    @(negedge clk);
    load_ena = v.ld; store_ena = ~v.ld; wen = v.wen; eew_loadstore = v.eew;
    aluresult0 = v.a0; aluresult1 = v.a1; storedata0 = v.sd0; storedata1 = v.sd1;
    vd = v.vd; woffset0 = v.wo0; woffset1 = v.wo1; dmem_busy = 1'b0;
    #1 res_stall_accept = stall;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        load_ena = 1'b0;
        store_ena = 1'b0;
      end
      if (dmem_ren && dmem_wen) res_both_hi++;
      if (dmem_ren || dmem_wen) begin
        res_req_cycles++;
        dmem_busy = (res_req_cycles <= v.busy_n);
        dmem_load = mem_model(dmem_addr);
        if (!dmem_busy) begin
          res_nreq++;
          if (res_nreq == 1) begin
            res_addr_first = dmem_addr; res_be_first = dmem_byte_en; res_st_first = dmem_store;
          end
          res_addr_last = dmem_addr; res_be_last = dmem_byte_en; res_st_last = dmem_store;
        end
      end else begin
        dmem_busy = 1'b0;
      end
      if (wb_valid) begin
        res_lat = k;
        res_wbwen = wb_wen; res_d0 = wb_data0; res_d1 = wb_data1; res_mis = wb_misaligned;
        res_vd = wb_vd; res_wo0 = wb_woffset0; res_wo1 = wb_woffset1;
        res_done_dmem = dmem_ren | dmem_wen;
        res_done_stall = stall;
        break;
      end else if (!stall) begin
        res_stall_low++;
      end
    end
    @(negedge clk);
    res_post_valid = wb_valid;
    dmem_busy = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    check({p, "_latency"}, res_lat, v.exp_lat);
    check({p, "_stall_accept"}, {31'h0, res_stall_accept}, 32'h1);
    check({p, "_stall_low"}, res_stall_low, 32'h0);
    check({p, "_both_req"}, res_both_hi, 32'h0);
    check({p, "_done_dmem"}, {31'h0, res_done_dmem}, 32'h0);
    check({p, "_done_stall"}, {31'h0, res_done_stall}, 32'h0);
    check({p, "_single_pulse"}, {31'h0, res_post_valid}, 32'h0);
    check({p, "_wb_wen"}, {30'h0, res_wbwen}, {30'h0, v.exp_wbwen});
    check({p, "_wb_mis"}, {31'h0, res_mis}, {31'h0, v.exp_mis});
    check({p, "_wb_vd"}, {27'h0, res_vd}, {27'h0, v.vd});
    check({p, "_wb_wo"}, {22'h0, res_wo1, res_wo0}, {22'h0, v.wo1, v.wo0});
    check({p, "_nreq"}, res_nreq, v.exp_nreq);
    if (v.exp_wbwen[0]) check({p, "_wb_data0"}, res_d0, v.exp_d0);
    if (v.exp_wbwen[1]) check({p, "_wb_data1"}, res_d1, v.exp_d1);
    if (v.exp_nreq > 0) begin
      check({p, "_addr_first"}, res_addr_first, v.exp_addr_first);
      check({p, "_addr_last"}, res_addr_last, v.exp_addr_last);
      check({p, "_be_first"}, {28'h0, res_be_first}, {28'h0, v.exp_be_first});
      check({p, "_be_last"}, {28'h0, res_be_last}, {28'h0, v.exp_be_last});
      if (!v.ld) begin
        check({p, "_store_first"}, res_st_first, v.exp_st_first);
        check({p, "_store_last"}, res_st_last, v.exp_st_last);
      end
    end
  endtask

  initial begin
    int activity;
    int pulses;
    total = 0;
    bad = 0;
    clearInputs();

    //            ld  wen    eew   a0           a1           sd0           sd1           vd     wo0    wo1   bsy lat wbwen  d0            d1            mis nreq addr_first   addr_last    be_f     be_l     st_f          st_l
    vecs[0] = '{1'b1, 2'b11, 2'd2, 32'h100, 32'h104, 32'h0,        32'h0,        5'd3,  5'd0,  5'd1,  0, 3, 2'b11, 32'hDEADBEEF, 32'h12345678, 1'b0, 2, 32'h100, 32'h104, 4'b1111, 4'b1111, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 2'b01, 2'd0, 32'h203, 32'h0,   32'hA5,       32'h0,        5'd4,  5'd2,  5'd0,  0, 2, 2'b00, 32'h0,        32'h0,        1'b0, 1, 32'h200, 32'h200, 4'b1000, 4'b1000, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 2'b11, 2'd1, 32'h302, 32'h300, 32'h0,        32'h0,        5'd7,  5'd1,  5'd2,  0, 3, 2'b11, 32'h0000CAFE, 32'h0000F00D, 1'b0, 2, 32'h300, 32'h300, 4'b1100, 4'b0011, 32'h0,        32'h0};
    vecs[3] = '{1'b1, 2'b11, 2'd2, 32'h100, 32'h101, 32'h0,        32'h0,        5'd8,  5'd3,  5'd4,  0, 3, 2'b01, 32'hDEADBEEF, 32'h0,        1'b1, 1, 32'h100, 32'h100, 4'b1111, 4'b1111, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 2'b10, 2'd0, 32'h0,   32'h105, 32'h0,        32'h0,        5'd9,  5'd0,  5'd5,  0, 2, 2'b10, 32'h0,        32'h00000056, 1'b0, 1, 32'h104, 32'h104, 4'b0010, 4'b0010, 32'h0,        32'h0};
    vecs[5] = '{1'b0, 2'b11, 2'd1, 32'h402, 32'h400, 32'h1234ABCD, 32'h00007777, 5'd10, 5'd6,  5'd7,  0, 3, 2'b00, 32'h0,        32'h0,        1'b0, 2, 32'h400, 32'h400, 4'b1100, 4'b0011, 32'hABCDABCD, 32'h77777777};
    vecs[6] = '{1'b0, 2'b11, 2'd2, 32'h502, 32'h504, 32'h0,        32'h11223344, 5'd11, 5'd8,  5'd9,  0, 3, 2'b00, 32'h0,        32'h0,        1'b1, 1, 32'h504, 32'h504, 4'b1111, 4'b1111, 32'h11223344, 32'h11223344};
    vecs[7] = '{1'b1, 2'b01, 2'd3, 32'h104, 32'h0,   32'h0,        32'h0,        5'd12, 5'd10, 5'd11, 0, 2, 2'b01, 32'h12345678, 32'h0,        1'b0, 1, 32'h104, 32'h104, 4'b1111, 4'b1111, 32'h0,        32'h0};
    vecs[8] = '{1'b1, 2'b11, 2'd0, 32'h103, 32'h302, 32'h0,        32'h0,        5'd13, 5'd12, 5'd13, 0, 3, 2'b11, 32'h000000DE, 32'h000000FE, 1'b0, 2, 32'h100, 32'h300, 4'b1000, 4'b0100, 32'h0,        32'h0};
    busy_vec = '{1'b1, 2'b11, 2'd1, 32'h302, 32'h300, 32'h0,       32'h0,        5'd14, 5'd1,  5'd2,  3, 6, 2'b11, 32'h0000CAFE, 32'h0000F00D, 1'b0, 2, 32'h300, 32'h300, 4'b1100, 4'b0011, 32'h0,        32'h0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_dmem_req", {30'h0, dmem_ren, dmem_wen}, 32'h0);
    check("reset_dmem_addr", dmem_addr, 32'h0);
    check("reset_dmem_be", {28'h0, dmem_byte_en}, 32'h0);
    check("reset_dmem_store", dmem_store, 32'h0);
    check("reset_wb_flags", {29'h0, wb_valid, wb_wen}, 32'h0);
    check("reset_wb_data0", wb_data0, 32'h0);
    check("reset_wb_data1", wb_data1, 32'h0);
    check("reset_wb_ids", {17'h0, wb_vd, wb_woffset0, wb_woffset1}, 32'h0);
    check("reset_wb_mis", {31'h0, wb_misaligned}, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Lane0 sees busy for three cycles: four request cycles on lane0 plus one on lane1.
    applyStimulus(busy_vec);
    checkOutput(busy_vec, 99);
    check("busy_req_cycles", res_req_cycles, 32'd5);

    // Reset while lane1 is waiting on a busy memory abandons the request.
    @(negedge clk);
    load_ena = 1'b1; store_ena = 1'b0; wen = 2'b11; eew_loadstore = 2'd2;
    aluresult0 = 32'h100; aluresult1 = 32'h104; dmem_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load_ena = 1'b0;
    dmem_load = mem_model(dmem_addr);
    @(negedge clk);
    check("rst_lane1_ren", {31'h0, dmem_ren}, 32'h1);
    check("rst_lane1_addr", dmem_addr, 32'h104);
    dmem_busy = 1'b1;
    @(negedge clk);
    check("rst_lane1_hold", {30'h0, dmem_ren, stall}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_busy = 1'b0;
    check("rst_abort_outputs", {29'h0, dmem_ren, stall, wb_valid}, 32'h0);
    check("rst_abort_data0", wb_data0, 32'h0);
    pulses = 0;
    activity = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wb_valid) pulses++;
      if (dmem_ren || dmem_wen || stall) activity++;
    end
    check("rst_abort_no_wb", pulses, 32'h0);
    check("rst_abort_no_reissue", activity, 32'h0);

    // Load with no lanes enabled is ignored entirely.
    @(negedge clk);
    load_ena = 1'b1; wen = 2'b00; aluresult0 = 32'h100; eew_loadstore = 2'd2;
    #1 check("empty_req_stall", {31'h0, stall}, 32'h0);
    activity = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (dmem_ren || dmem_wen || stall || wb_valid) activity++;
    end
    check("empty_req_activity", activity, 32'h0);
    load_ena = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
